// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, mid-bit sampling on s_tick, parity/frame/overrun/break detection.
// Optional build macro UART_RX_MAJORITY_EN: each sample point becomes a 2-of-3 vote over ticks P-2, P-1, P.
module uart_rx_os #(
    parameter int N      = 8,
    parameter int M      = 1,
    parameter int PARITY = 0,
    parameter int OS     = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_tick,
    input  logic         rx,
    output logic [N-1:0] data_out,
    output logic         valid,
    input  logic         ready,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overrun_err,
    output logic         busy
);
    localparam int SW = $clog2(OS);
    localparam int BW = $clog2(N);
    localparam logic [SW-1:0] S_MID     = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_END     = SW'(OS - 1);
    localparam logic [BW-1:0] B_LAST    = BW'(N - 1);
    localparam logic          STOP_LAST = 1'(M - 1);
    localparam bit            PAR_EN    = (PARITY != 0);
    localparam bit            PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_BRK
    } state_t;

    state_t          state;
    logic [SW-1:0]   s_cnt;
    logic [BW-1:0]   bit_cnt;
    logic            stop_cnt;
    logic [N-1:0]    shreg;
    logic            perr_q;
    logic            ferr_q;
    logic            done;
    logic            rx_meta;
    logic            rx_s;
    logic            sample;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // vote[1] holds rx_s from tick P-2 and vote[0] from tick P-1 when s_cnt reaches P
    logic [1:0] vote;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vote <= 2'b11;
        end else if (s_tick) begin
            vote <= {vote[0], rx_s};
        end
    end

    assign sample = (vote[1] & vote[0]) | (vote[1] & rx_s) | (vote[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            s_cnt    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        s_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (s_cnt == S_MID) begin
                            s_cnt   <= '0;
                            bit_cnt <= '0;
                            state   <= sample ? ST_IDLE : ST_DATA;
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (s_cnt == S_END) begin
                            s_cnt <= '0;
                            shreg <= {sample, shreg[N-1:1]};
                            if (bit_cnt == B_LAST) begin
                                bit_cnt  <= '0;
                                stop_cnt <= 1'b0;
                                perr_q   <= 1'b0;
                                ferr_q   <= 1'b0;
                                state    <= PAR_EN ? ST_PAR : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                ST_PAR: begin
                    if (s_tick) begin
                        if (s_cnt == S_END) begin
                            s_cnt  <= '0;
                            perr_q <= (((^shreg) ^ sample) != PAR_ODD);
                            state  <= ST_STOP;
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (s_tick) begin
                        if (s_cnt == S_END) begin
                            s_cnt <= '0;
                            if (!sample) begin
                                ferr_q <= 1'b1;
                            end
                            if (stop_cnt == STOP_LAST) begin
                                stop_cnt <= 1'b0;
                                done     <= 1'b1;
                                // a low stop over all-zero data is a break; hold off restart until the line idles
                                state    <= (!sample && shreg == '0) ? ST_BRK : ST_IDLE;
                            end else begin
                                stop_cnt <= stop_cnt + 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                ST_BRK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // delivery: a completed frame loads unless an unaccepted word is still held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out    <= '0;
            valid       <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done) begin
                if (valid && !ready) begin
                    overrun_err <= 1'b1;
                end else begin
                    data_out   <= shreg;
                    parity_err <= perr_q;
                    frame_err  <= ferr_q;
                    valid      <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
